alu_issue_ctrl: RTL
===================

// Module: alu_issue_ctrl
// PURPOSE
//  Sequences one ALU instruction at a time through the ALU/flag-select datapath.
//  Accepts an instruction over a valid/ready handshake and evaluates its condition code against the
//  architectural NZCV register. Drives the ALU opcode, waits out multi-cycle MUL, then commits the
//  writeback and the flag update. Sits between decode and the ALU + flag_sel pair.
// PARAMETERS
//  DATA_WIDTH   16  ALU result / writeback width
//  MUL_LATENCY  3   EXEC cycles for opcode 2 (MUL); legal range 1..15
// PORTS
//  clk          in   1           clock; all state changes on rising edge
//  reset_n      in   1           synchronous active-low reset
//  in_valid     in   1           instruction offered
//  in_ready     out  1           controller can accept (state IDLE)
//  in_opcode    in   4           0 ADD, 1 SUB, 2 MUL, 11 CMP, others pass-through ops
//  in_cond      in   2           00 always, 01 EQ (Z), 10 GE (N==V), 11 LT (N!=V)
//  in_rd        in   4           destination register index
//  alu_opcode   out  4           opcode held to ALU and flag_sel while busy
//  alu_result   in   DATA_WIDTH  ALU result, valid in COMMIT
//  fs_update_flag in 1           flag_sel: update N,Z
//  fs_update_cv in   1           flag_sel: update C,V
//  fs_neg/fs_zero/fs_carry/fs_ovf in 1 each  flag values from flag_sel
//  wb_en        out  1           register-file write strobe
//  wb_rd        out  4           write index
//  wb_data      out  DATA_WIDTH  write data
//  flags        out  4           architectural {N,Z,C,V}
//  cond_fail    out  1           1-cycle pulse: instruction accepted but squashed
// BEHAVIOUR
//  Reset (reset_n=0 at an edge): state IDLE, flags=4'b0000, alu_opcode=0, latched rd=0, counter=0,
//   cond_fail=0. wb_en=0, wb_rd=0, wb_data=0 while reset_n=0. Any in-flight instruction is dropped,
//   including mid-EXEC MUL.
//  States: IDLE -> EXEC -> COMMIT -> IDLE.
//  IDLE: in_ready=1. Accept on in_valid&in_ready. cond evaluated combinationally on current flags.
//   pass: latch opcode->alu_opcode and rd; cnt<=(opcode==2)?MUL_LATENCY-1:0; next EXEC.
//   fail: cond_fail=1 in next cycle only; flags, alu_opcode unchanged; stay IDLE (back-to-back ok).
//  EXEC: in_ready=0; in_valid ignored (no accept, no buffering). cnt==0 -> COMMIT, else cnt--.
//  COMMIT: in_ready=0. wb_en=(alu_opcode!=11), wb_rd=latched rd, wb_data=alu_result (combinational
//   from state). At the COMMIT edge: fs_update_flag -> N<=fs_neg, Z<=fs_zero; fs_update_cv ->
//   C<=fs_carry, V<=fs_ovf; unset groups hold. Next IDLE.
//  wb_en=0, wb_rd=0, wb_data=0 outside COMMIT.
//  Latency, accept at edge T: non-MUL COMMIT in cycle T+2; MUL in T+1+MUL_LATENCY. New flags visible
//   in the cycle after COMMIT. Next accept is possible in that same cycle, so a dependent cond always
//   sees the committed flags (no bypass needed).
//  Throughput: 1 instr / 3 cycles (non-MUL); squashed instr 1 / cycle.
//  Illegal MUL_LATENCY=0 is treated as 1. cnt is 4 bits and never wraps below 0.
// TESTING
//  1 ADD op0 cond00 rd3, alu_result=0, fs_zero=1, upd=1/1 -> wb_en@T+2 rd=3 data=0; flags=0100 @T+3
//  2 MUL op2, MUL_LATENCY=3, result 0x0012 -> in_ready=0 T+1..T+4; wb_en only @T+4; C,V unchanged
//  3 CMP op11 Z-result, then SUB cond01 -> CMP no wb_en, Z=1; SUB executes, wb_en after 3 cycles
//  4 flags N=1 V=0, ADD cond10 -> cond_fail pulse @T+1, no wb_en, flags unchanged, in_ready held 1
//  5 reset_n=0 during MUL EXEC -> next cycle IDLE, in_ready=1, flags=0000, no wb_en ever issued
//  6 in_valid held high 6 cycles with ADD -> exactly 2 accepts (T, T+3), 2 wb_en pulses

Source files
------------

// File: rtl/alu_issue_if.sv
// Instruction handshake, ALU/flag_sel datapath and writeback signals around the issue controller.
// The master side is decode plus the ALU/flag_sel pair; the slave side is the controller.
interface alu_issue_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            in_opcode;
  logic [1:0]            in_cond;
  logic [3:0]            in_rd;
  logic [3:0]            alu_opcode;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  fs_update_flag;
  logic                  fs_update_cv;
  logic                  fs_neg;
  logic                  fs_zero;
  logic                  fs_carry;
  logic                  fs_ovf;
  logic                  wb_en;
  logic [3:0]            wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [3:0]            flags;
  logic                  cond_fail;

  modport master (
    output in_valid, in_opcode, in_cond, in_rd, alu_result,
           fs_update_flag, fs_update_cv, fs_neg, fs_zero, fs_carry, fs_ovf,
    input  in_ready, alu_opcode, wb_en, wb_rd, wb_data, flags, cond_fail
  );

  modport slave (
    input  in_valid, in_opcode, in_cond, in_rd, alu_result,
           fs_update_flag, fs_update_cv, fs_neg, fs_zero, fs_carry, fs_ovf,
    output in_ready, alu_opcode, wb_en, wb_rd, wb_data, flags, cond_fail
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Single-issue ALU sequencer: condition check against NZCV, multi-cycle MUL wait,
// then writeback and flag commit. Flags are held as {N,Z,C,V}.
module alu_issue_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int MUL_LATENCY = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  alu_issue_if.slave bus
);

  // A zero latency still needs one EXEC cycle; the counter is only 4 bits wide.
  localparam int         MUL_LAT_EFF  = (MUL_LATENCY < 1)  ? 1  :
                                        (MUL_LATENCY > 15) ? 15 : MUL_LATENCY;
  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT_EFF - 1);
  localparam logic [3:0] OP_MUL       = 4'd2;
  localparam logic [3:0] OP_CMP       = 4'd11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] flags_q, flags_d;
  logic [3:0] alu_opcode_q, alu_opcode_d;
  logic [3:0] rd_q, rd_d;
  logic       cond_fail_q, cond_fail_d;

  logic       accept;
  logic       cond_pass;
  logic       in_commit;
  logic [DATA_WIDTH-1:0] wb_data_c;

  always_comb begin
    cond_pass = 1'b1;
    unique case (bus.in_cond)
      2'b00:   cond_pass = 1'b1;
      2'b01:   cond_pass = flags_q[2];
      2'b10:   cond_pass = (flags_q[3] == flags_q[0]);
      default: cond_pass = (flags_q[3] != flags_q[0]);
    endcase
  end

  assign accept = bus.in_valid && (state_q == IDLE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flags_d      = flags_q;
    alu_opcode_d = alu_opcode_q;
    rd_d         = rd_q;
    cond_fail_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (cond_pass) begin
            alu_opcode_d = bus.in_opcode;
            rd_d         = bus.in_rd;
            cnt_d        = (bus.in_opcode == OP_MUL) ? MUL_CNT_INIT : 4'd0;
            state_d      = EXEC;
          end else begin
            cond_fail_d  = 1'b1;
          end
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d = COMMIT;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      COMMIT: begin
        // N,Z and C,V are independent groups; a group not flagged for update holds.
        if (bus.fs_update_flag) begin
          flags_d[3] = bus.fs_neg;
          flags_d[2] = bus.fs_zero;
        end
        if (bus.fs_update_cv) begin
          flags_d[1] = bus.fs_carry;
          flags_d[0] = bus.fs_ovf;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      flags_q      <= 4'b0000;
      alu_opcode_q <= 4'd0;
      rd_q         <= 4'd0;
      cond_fail_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flags_q      <= flags_d;
      alu_opcode_q <= alu_opcode_d;
      rd_q         <= rd_d;
      cond_fail_q  <= cond_fail_d;
    end
  end

  // Writeback is gated by reset_n so nothing is written while reset is asserted mid-COMMIT.
  assign in_commit = (state_q == COMMIT) && reset_n;
  assign wb_data_c = in_commit ? bus.alu_result : '0;

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.flags      = flags_q;
  assign bus.cond_fail  = cond_fail_q;
  assign bus.wb_en      = in_commit && (alu_opcode_q != OP_CMP);
  assign bus.wb_rd      = in_commit ? rd_q : 4'd0;
  assign bus.wb_data    = wb_data_c;

endmodule
